// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB slave-side bus bundle for opb_register_bank_simulink2ppc.
// OPB numbers bit 0 as MSB; here vectors are [31:0], so OPB bit n is vector bit 31-n.
interface opb_register_bank_simulink2ppc_if;
    logic [31:0] OPB_ABus;
    logic [3:0]  OPB_BE;
    logic [31:0] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;
    logic [31:0] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_simulink2ppc.sv
// Read-only OPB register bank exposing N_CH fabric words as one coherent snapshot.
// Optional `SNAP_TIMESTAMP_EN adds a cycle counter latched on each capture.
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_4100,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_41FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          N_CH         = 4,
    parameter int          C_UWIDTH     = 32,
    parameter int          C_SIGNED     = 0
) (
    input  logic                       OPB_Clk,
    input  logic                       OPB_Rst,
    opb_register_bank_simulink2ppc_if.slave bus,
    input  logic [N_CH*C_UWIDTH-1:0]   user_data_in,
    input  logic                       user_valid
);

    typedef enum logic {S_IDLE, S_ACK} state_e;

    localparam logic [7:0]  N_CH_B = 8'(N_CH);
    localparam logic [31:0] TS_IDX = 32'(N_CH + 2);

    state_e      state_q, state_d;
    logic        xfer_ack_q, xfer_ack_d;
    logic [31:0] sl_dbus_q, sl_dbus_d;
    logic        auto_q, auto_d;
    logic        pending_q, pending_d;
    logic [31:0] snap_count_q, snap_count_d;
    logic [31:0] shadow_q [N_CH];
    logic [31:0] shadow_d [N_CH];

    logic        hit;
    logic [31:0] offset;
    logic [31:0] word_idx;
    logic        ctrl_wr;
    logic        snap_req;
    logic        capture;
    logic [31:0] rd_word;

    function automatic logic [31:0] extend(input logic [C_UWIDTH-1:0] v);
        logic [31:0] r;
        r = (C_SIGNED != 0 && v[C_UWIDTH-1]) ? '1 : '0;
        r[C_UWIDTH-1:0] = v;
        return r;
    endfunction

    assign hit      = bus.OPB_select && (bus.OPB_ABus >= C_BASEADDR) && (bus.OPB_ABus <= C_HIGHADDR);
    assign offset   = bus.OPB_ABus - C_BASEADDR;
    assign word_idx = {2'b00, offset[31:2]};

    // CTRL byte lane 3 (BE[3], vector bit 0) carries both the request and auto bits.
    assign ctrl_wr  = (state_q == S_IDLE) && hit && !bus.OPB_RNW && (word_idx == 32'd0) && bus.OPB_BE[0];
    assign snap_req = ctrl_wr && bus.OPB_DBus[0];
    assign capture  = user_valid && (auto_q || pending_q);

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] stamp_q, stamp_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        stamp_d = capture ? cycle_q : stamp_q;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            cycle_q <= '0;
            stamp_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            stamp_q <= stamp_d;
        end
    end
`endif

    // Read data is built from current (pre-capture) state, so a read that loads
    // on a capture edge returns the old snapshot and count.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        rd_word = '0;
        if (word_idx == 32'd0) begin
            rd_word = {N_CH_B, 21'd0, pending_q, auto_q, 1'b0};
        end else if (word_idx == 32'd1) begin
            rd_word = snap_count_q;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (word_idx == 32'(i + 2)) rd_word = shadow_q[i];
        end
`ifdef SNAP_TIMESTAMP_EN
        if (word_idx == TS_IDX) rd_word = stamp_q;
`else
        if (word_idx == TS_IDX) rd_word = '0;
`endif
    end

    always_comb begin
        auto_d       = ctrl_wr ? bus.OPB_DBus[1] : auto_q;
        snap_count_d = capture ? snap_count_q + 32'd1 : snap_count_q;
        if (auto_q || capture) pending_d = 1'b0;
        else                   pending_d = pending_q || snap_req;
        shadow_d = shadow_q;
        if (capture) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow_d[i] = extend(user_data_in[i*C_UWIDTH +: C_UWIDTH]);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        xfer_ack_d = 1'b0;
        sl_dbus_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    state_d    = S_ACK;
                    xfer_ack_d = 1'b1;
                    sl_dbus_d  = bus.OPB_RNW ? rd_word : 32'd0;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
        if (!OPB_Rst) begin
            state_q      <= S_IDLE;
            xfer_ack_q   <= 1'b0;
            sl_dbus_q    <= '0;
            auto_q       <= 1'b0;
            pending_q    <= 1'b0;
            snap_count_q <= '0;
            // NOTE: the shadow array is reset because software may read it before any capture.
            shadow_q     <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= state_d;
            xfer_ack_q   <= xfer_ack_d;
            sl_dbus_q    <= sl_dbus_d;
            auto_q       <= auto_d;
            pending_q    <= pending_d;
            snap_count_q <= snap_count_d;
            shadow_q     <= shadow_d;
        end
    end

    assign bus.Sl_DBus    = sl_dbus_q;
    assign bus.Sl_xferAck = xfer_ack_q;
    assign bus.Sl_errAck  = 1'b0;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = 1'b0;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.OPB_seqAddr, bus.OPB_BE[3:1], bus.OPB_DBus[31:2], offset[1:0]};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed scoreboard bench: two bank instances (4x32 unsigned, 1x8 signed) on one OPB.
module tb_opb_register_bank_simulink2ppc;

    localparam logic [31:0] BASE_A = 32'h0100_4100;
    localparam logic [31:0] BASE_B = 32'h0100_4200;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] data_a = '0;
    logic [7:0]   data_b = '0;
    logic         user_valid = 1'b0;
    logic [31:0]  ts_exp = '0;

    int          n_checks = 0;
    int          n_fails = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc_if bus_a ();
    opb_register_bank_simulink2ppc_if bus_b ();

    assign bus_b.OPB_ABus    = bus_a.OPB_ABus;
    assign bus_b.OPB_BE      = bus_a.OPB_BE;
    assign bus_b.OPB_DBus    = bus_a.OPB_DBus;
    assign bus_b.OPB_RNW     = bus_a.OPB_RNW;
    assign bus_b.OPB_select  = bus_a.OPB_select;
    assign bus_b.OPB_seqAddr = bus_a.OPB_seqAddr;

    wire        ack  = bus_a.Sl_xferAck | bus_b.Sl_xferAck;
    wire [31:0] dbus = bus_a.Sl_DBus | bus_b.Sl_DBus;

    opb_register_bank_simulink2ppc #(
        .N_CH(4), .C_UWIDTH(32), .C_SIGNED(0)
    ) dut_a (
        .OPB_Clk(clk), .OPB_Rst(rst_n), .bus(bus_a.slave),
        .user_data_in(data_a), .user_valid(user_valid)
    );

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR(BASE_B), .C_HIGHADDR(32'h0100_42FF),
        .N_CH(1), .C_UWIDTH(8), .C_SIGNED(1)
    ) dut_b (
        .OPB_Clk(clk), .OPB_Rst(rst_n), .bus(bus_b.slave),
        .user_data_in(data_b), .user_valid(user_valid)
    );

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] tb_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One OPB transfer; expected read data goes through the scoreboard queue.
    task automatic xfer(input string tag, input logic [31:0] addr, input logic rnw,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] exp_rd);
        int          cyc;
        logic [31:0] exp;
        exp_q.push_back(rnw ? exp_rd : 32'h0);
        @(negedge clk);
        bus_a.OPB_ABus   = addr;
        bus_a.OPB_RNW    = rnw;
        bus_a.OPB_DBus   = wdata;
        bus_a.OPB_BE     = be;
        bus_a.OPB_select = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!ack && cyc < 8);
        check({tag, " latency"}, 32'(cyc), 32'd1);
        exp = exp_q.pop_front();
        check({tag, " data"}, dbus, exp);
        bus_a.OPB_select = 1'b0;
        bus_a.OPB_RNW    = 1'b1;
        bus_a.OPB_DBus   = '0;
        @(posedge clk);
        #1;
        check({tag, " ack one cycle"}, {31'd0, ack}, 32'd0);
        check({tag, " dbus idle"}, dbus, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        xfer(tag, addr, 1'b1, 32'd0, 4'hF, exp);
    endtask

    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        xfer(tag, addr, 1'b0, data, be, 32'd0);
    endtask

    task automatic miss(input string tag, input logic [31:0] addr);
        int seen;
        @(negedge clk);
        bus_a.OPB_ABus   = addr;
        bus_a.OPB_RNW    = 1'b1;
        bus_a.OPB_select = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack || dbus != 32'd0) seen++;
        end
        check({tag, " no response"}, 32'(seen), 32'd0);
        bus_a.OPB_select = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        bus_a.OPB_ABus    = '0;
        bus_a.OPB_BE      = '0;
        bus_a.OPB_DBus    = '0;
        bus_a.OPB_RNW     = 1'b1;
        bus_a.OPB_select  = 1'b0;
        bus_a.OPB_seqAddr = 1'b0;

        // Reset state and identity reads.
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", {31'd0, ack}, 32'd0);
        check("reset dbus", dbus, 32'd0);
        check("tied outputs", {29'd0, bus_a.Sl_errAck, bus_a.Sl_retry, bus_a.Sl_toutSup}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd("ctrl after reset", BASE_A, 32'h0400_0000);
        rd("count after reset", BASE_A + 32'h04, 32'd0);
        rd("ch0 after reset", BASE_A + 32'h08, 32'd0);

        // Manual snapshot: request with valid high captures on the following edge.
        data_a = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1234_5678};
        user_valid = 1'b1;
        wr("req valid high", BASE_A, 32'h1, 4'hF);
        user_valid = 1'b0;
        data_a = '1;
        rd("ch0 snap1", BASE_A + 32'h08, 32'h1234_5678);
        rd("ch1 snap1", BASE_A + 32'h0C, 32'hDEAD_BEEF);
        rd("ch3 snap1", BASE_A + 32'h14, 32'h3333_3333);
        rd("count snap1", BASE_A + 32'h04, 32'd1);
        rd("ctrl idle", BASE_A, 32'h0400_0000);
        rd("unmapped offset", BASE_A + 32'h40, 32'd0);

        // Two requests without valid merge into one pending capture.
        wr("req a", BASE_A, 32'h1, 4'hF);
        wr("req b", BASE_A, 32'h1, 4'hF);
        rd("ctrl pending", BASE_A, 32'h0400_0004);
        rd("count held", BASE_A + 32'h04, 32'd1);
        data_a = {32'h0, 32'h0, 32'h5A5A_0002, 32'hA5A5_0001};
        @(negedge clk) user_valid = 1'b1;
        @(negedge clk) user_valid = 1'b0;
        rd("count merged", BASE_A + 32'h04, 32'd2);
        rd("ctrl cleared", BASE_A, 32'h0400_0000);
        rd("ch0 snap2", BASE_A + 32'h08, 32'hA5A5_0001);

        // Byte-enable gating and writes to read-only offsets.
        wr("req without be3", BASE_A, 32'h1, 4'hE);
        rd("ctrl be gated", BASE_A, 32'h0400_0000);
        wr("write ro count", BASE_A + 32'h04, 32'hFFFF_FFFF, 4'hF);
        rd("count after ro write", BASE_A + 32'h04, 32'd2);

        // Auto mode: every valid cycle captures.
        wr("auto on", BASE_A, 32'h2, 4'hF);
        rd("ctrl auto", BASE_A, 32'h0400_0002);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            user_valid = 1'b1;
            data_a[31:0] = 32'(100 + i);
        end
        @(negedge clk) user_valid = 1'b0;
        rd("count auto", BASE_A + 32'h04, 32'd7);
        rd("ch0 auto last", BASE_A + 32'h08, 32'd104);

        // Read loading on a capture edge sees the pre-capture value.
        data_a[31:0] = 32'h0000_B0B0;
        user_valid = 1'b1;
        rd("collision ch0", BASE_A + 32'h08, 32'd104);
        user_valid = 1'b0;
        rd("count collision", BASE_A + 32'h04, 32'd9);
        rd("ch0 post collision", BASE_A + 32'h08, 32'h0000_B0B0);

        // Counter wrap.
        @(negedge clk);
        force dut_a.snap_count_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut_a.snap_count_q;
        rd("count preloaded", BASE_A + 32'h04, 32'hFFFF_FFFF);
        @(negedge clk);
        user_valid = 1'b1;
`ifdef SNAP_TIMESTAMP_EN
        ts_exp = tb_cyc;
`endif
        @(negedge clk) user_valid = 1'b0;
        rd("count wrapped", BASE_A + 32'h04, 32'd0);
        rd("timestamp slot", BASE_A + 32'h18, ts_exp);

        // Narrow signed channel on the second bank.
        data_b = 8'h80;
        user_valid = 1'b1;
        wr("b req", BASE_B, 32'h1, 4'hF);
        user_valid = 1'b0;
        rd("b ctrl", BASE_B, 32'h0100_0000);
        rd("b ch0 signed", BASE_B + 32'h08, 32'hFFFF_FF80);
        rd("b count", BASE_B + 32'h04, 32'd1);

        // Out-of-window accesses.
        miss("above windows", 32'h0100_4300);
        miss("below base", 32'h0100_40FC);

        // Reset during the ACK cycle.
        @(negedge clk);
        bus_a.OPB_ABus   = BASE_A;
        bus_a.OPB_RNW    = 1'b1;
        bus_a.OPB_select = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset ack", {31'd0, ack}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async reset ack", {31'd0, ack}, 32'd0);
        check("async reset dbus", dbus, 32'd0);
        bus_a.OPB_select = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ack) seen++;
        end
        check("no ack after abort", 32'(seen), 32'd0);
        rd("ch0 after reset2", BASE_A + 32'h08, 32'd0);
        rd("count after reset2", BASE_A + 32'h04, 32'd0);
        rd("ctrl after reset2", BASE_A, 32'h0400_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
